// File: rtl/mem_stage_if.sv
// ---------------------------------------------------------------------------
// mem_stage_if
// Purpose : Data-memory request/acknowledge bus between the MEM stage and
//           the data memory. The MEM stage is the master; memory is the slave.
// Signals :
//   dmem_req   master->slave  memory request, held until acknowledged
//   dmem_we    master->slave  1 = write, 0 = read
//   dmem_addr  master->slave  32-bit word address
//   dmem_wdata master->slave  32-bit store data
//   dmem_rdata slave->master  32-bit load data, valid when dmem_ack=1
//   dmem_ack   slave->master  access complete
// ---------------------------------------------------------------------------
interface mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_wdata,
    input  dmem_rdata,
    input  dmem_ack
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_wdata,
    output dmem_rdata,
    output dmem_ack
  );
endinterface

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
// Purpose : MEM stage of a 5-stage RV32 pipeline. Issues word loads/stores on
//           the data-memory bus, stalls upstream while an access is pending,
//           aborts accesses that are never acknowledged, flags misaligned
//           addresses, resolves the branch redirect and holds MEM/WB.
// Parameters:
//   TIMEOUT_CYCLES  max cycles dmem_req stays high without dmem_ack (>=1)
//   CNT_W           timeout counter width, must hold TIMEOUT_CYCLES
// Ports:
//   clk, reset                 clock; synchronous active-low reset
//   mem_re_in / mem_we_in      load / store request from EX/MEM
//   reg_file_write_in          register write enable from EX/MEM
//   branch_in, add_pc_in       branch taken and its target from EX/MEM
//   select_mux_4_in            writeback source select
//   reg_b_in, alu_in           store data, ALU result / memory address
//   bus                        data-memory bus (master modport)
//   stall_out                  hold PC, IF/ID, ID/EX, EX/MEM (combinational)
//   pc_src_out                 redirect fetch (combinational)
//   branch_target_out          redirect address (combinational)
//   reg_file_write_out, select_mux_4_out, mem_data_out, alu_out,
//   misaligned_out, bus_err_out   MEM/WB pipeline register
// ---------------------------------------------------------------------------
module mem_stage #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         mem_re_in,
  input  logic         mem_we_in,
  input  logic         reg_file_write_in,
  input  logic         branch_in,
  input  logic [1:0]   select_mux_4_in,
  input  logic [31:0]  reg_b_in,
  input  logic [31:0]  alu_in,
  input  logic [31:0]  add_pc_in,
  mem_stage_if.master  bus,
  output logic         stall_out,
  output logic         pc_src_out,
  output logic [31:0]  branch_target_out,
  output logic         reg_file_write_out,
  output logic [1:0]   select_mux_4_out,
  output logic [31:0]  mem_data_out,
  output logic [31:0]  alu_out,
  output logic         misaligned_out,
  output logic         bus_err_out
);

  typedef enum logic [0:0] {S_IDLE, S_WAIT} state_t;

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             req_q;
  logic             we_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic             rfw_q;
  logic [1:0]       sel_q;
  logic [31:0]      mdata_q;
  logic [31:0]      alu_q;
  logic             mis_q;
  logic             err_q;

  logic access;
  logic aligned;
  logic timeout;
  logic stallRaw;

  assign access  = mem_re_in | mem_we_in;
  assign aligned = (alu_in[1:0] == 2'b00);
  assign timeout = (cnt_q == CntMax);
  assign cnt_d   = cnt_q + CntOne;

  // An aligned access stalls from the cycle it is presented until the cycle
  // its ack (or timeout) arrives, so the result lands in MEM/WB at that edge.
  always_comb begin
    stallRaw = 1'b0;
    case (state_q)
      S_IDLE:  stallRaw = access & aligned;
      S_WAIT:  stallRaw = ~(bus.dmem_ack | timeout);
      default: stallRaw = 1'b0;
    endcase
  end

  assign stall_out         = reset & stallRaw;
  assign pc_src_out        = reset & branch_in;
  assign branch_target_out = add_pc_in;

  // Single FSM block: bus request registers and the MEM/WB register. Edges
  // with stall high insert a bubble (write enable and flags cleared, data
  // fields held). The EX/MEM inputs stay frozen while stalled, so on ack the
  // instruction's fields are still valid on the inputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rfw_q   <= 1'b0;
      sel_q   <= '0;
      mdata_q <= '0;
      alu_q   <= '0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!access) begin
            rfw_q   <= reg_file_write_in;
            sel_q   <= select_mux_4_in;
            alu_q   <= alu_in;
            mdata_q <= '0;
            mis_q   <= 1'b0;
            err_q   <= 1'b0;
          end else if (!aligned) begin
            rfw_q   <= 1'b0;
            sel_q   <= select_mux_4_in;
            alu_q   <= alu_in;
            mdata_q <= '0;
            mis_q   <= 1'b1;
            err_q   <= 1'b0;
          end else begin
            req_q   <= 1'b1;
            we_q    <= mem_we_in;
            addr_q  <= alu_in;
            wdata_q <= reg_b_in;
            cnt_q   <= CntOne;
            state_q <= S_WAIT;
            rfw_q   <= 1'b0;
            mis_q   <= 1'b0;
            err_q   <= 1'b0;
          end
        end
        S_WAIT: begin
          // Ack is tested first so it wins over a coincident timeout.
          if (bus.dmem_ack) begin
            req_q   <= 1'b0;
            state_q <= S_IDLE;
            rfw_q   <= reg_file_write_in;
            sel_q   <= select_mux_4_in;
            alu_q   <= alu_in;
            mdata_q <= we_q ? 32'h0 : bus.dmem_rdata;
            mis_q   <= 1'b0;
            err_q   <= 1'b0;
          end else if (timeout) begin
            req_q   <= 1'b0;
            state_q <= S_IDLE;
            rfw_q   <= 1'b0;
            sel_q   <= select_mux_4_in;
            alu_q   <= alu_in;
            mdata_q <= '0;
            mis_q   <= 1'b0;
            err_q   <= 1'b1;
          end else begin
            cnt_q   <= cnt_d;
            rfw_q   <= 1'b0;
            mis_q   <= 1'b0;
            err_q   <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.dmem_req   = req_q;
  assign bus.dmem_we    = we_q;
  assign bus.dmem_addr  = addr_q;
  assign bus.dmem_wdata = wdata_q;

  assign reg_file_write_out = rfw_q;
  assign select_mux_4_out   = sel_q;
  assign mem_data_out       = mdata_q;
  assign alu_out            = alu_q;
  assign misaligned_out     = mis_q;
  assign bus_err_out        = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_stage
// Purpose : Directed self-checking bench for mem_stage with TIMEOUT_CYCLES=4.
//           Inputs change and outputs are sampled 1 time unit after each
//           rising edge; expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_re_in;
  logic        mem_we_in;
  logic        reg_file_write_in;
  logic        branch_in;
  logic [1:0]  select_mux_4_in;
  logic [31:0] reg_b_in;
  logic [31:0] alu_in;
  logic [31:0] add_pc_in;
  logic        stall_out;
  logic        pc_src_out;
  logic [31:0] branch_target_out;
  logic        reg_file_write_out;
  logic [1:0]  select_mux_4_out;
  logic [31:0] mem_data_out;
  logic [31:0] alu_out;
  logic        misaligned_out;
  logic        bus_err_out;

  int testsRun  = 0;
  int failCount = 0;

  mem_stage_if bus ();

  mem_stage #(.TIMEOUT_CYCLES(4), .CNT_W(5)) dut (
    .clk               (clk),
    .reset             (reset),
    .mem_re_in         (mem_re_in),
    .mem_we_in         (mem_we_in),
    .reg_file_write_in (reg_file_write_in),
    .branch_in         (branch_in),
    .select_mux_4_in   (select_mux_4_in),
    .reg_b_in          (reg_b_in),
    .alu_in            (alu_in),
    .add_pc_in         (add_pc_in),
    .bus               (bus),
    .stall_out         (stall_out),
    .pc_src_out        (pc_src_out),
    .branch_target_out (branch_target_out),
    .reg_file_write_out(reg_file_write_out),
    .select_mux_4_out  (select_mux_4_out),
    .mem_data_out      (mem_data_out),
    .alu_out           (alu_out),
    .misaligned_out    (misaligned_out),
    .bus_err_out       (bus_err_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic re, input logic we, input logic rfw,
                               input logic br, input logic [1:0] sel,
                               input logic [31:0] regB, input logic [31:0] alu,
                               input logic [31:0] addPc);
    mem_re_in         = re;
    mem_we_in         = we;
    reg_file_write_in = rfw;
    branch_in         = br;
    select_mux_4_in   = sel;
    reg_b_in          = regB;
    alu_in            = alu;
    add_pc_in         = addPc;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    reset          = 1'b0;
    bus.dmem_ack   = 1'b0;
    bus.dmem_rdata = 32'h0;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 32'h0, 32'h100, 32'h44);

    // Reset held two edges with a load pending
    tick();
    tick();
    checkOutput("rst_req",    {31'b0, bus.dmem_req},       32'h0);
    checkOutput("rst_stall",  {31'b0, stall_out},          32'h0);
    checkOutput("rst_rfw",    {31'b0, reg_file_write_out}, 32'h0);
    checkOutput("rst_alu",    alu_out,                     32'h0);
    checkOutput("rst_mdata",  mem_data_out,                32'h0);
    checkOutput("rst_target", branch_target_out,           32'h44);

    // Release reset, enter WAIT, then reset mid-WAIT
    reset = 1'b1;
    #1;
    checkOutput("pre_stall", {31'b0, stall_out}, 32'h1);
    tick();
    checkOutput("w_req", {31'b0, bus.dmem_req}, 32'h1);
    tick();
    reset = 1'b0;
    tick();
    checkOutput("rstw_req",   {31'b0, bus.dmem_req}, 32'h0);
    checkOutput("rstw_stall", {31'b0, stall_out},    32'h0);
    reset = 1'b1;

    // ALU op: must load immediately, proving state returned to IDLE
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 32'h0, 32'h10, 32'h0);
    checkOutput("alu_stall0", {31'b0, stall_out}, 32'h0);
    tick();
    checkOutput("alu_out",  alu_out,                     32'h10);
    checkOutput("alu_rfw",  {31'b0, reg_file_write_out}, 32'h1);
    checkOutput("alu_sel",  {30'b0, select_mux_4_out},   32'h1);
    checkOutput("alu_stall",{31'b0, stall_out},          32'h0);

    // Load at 0x100, ack on third request cycle
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 2'b10, 32'h0, 32'h100, 32'h0);
    checkOutput("ld_stall_n", {31'b0, stall_out}, 32'h1);
    tick();
    checkOutput("ld_req1",   {31'b0, bus.dmem_req},       32'h1);
    checkOutput("ld_we",     {31'b0, bus.dmem_we},        32'h0);
    checkOutput("ld_addr",   bus.dmem_addr,               32'h100);
    checkOutput("ld_stall1", {31'b0, stall_out},          32'h1);
    checkOutput("ld_bubble", {31'b0, reg_file_write_out}, 32'h0);
    checkOutput("ld_hold",   alu_out,                     32'h10);
    tick();
    checkOutput("ld_req2",   {31'b0, bus.dmem_req}, 32'h1);
    checkOutput("ld_stall2", {31'b0, stall_out},    32'h1);
    tick();
    checkOutput("ld_req3",   {31'b0, bus.dmem_req}, 32'h1);
    bus.dmem_ack   = 1'b1;
    bus.dmem_rdata = 32'hDEADBEEF;
    #1;
    checkOutput("ld_stall3", {31'b0, stall_out}, 32'h0);
    tick();
    bus.dmem_ack   = 1'b0;
    bus.dmem_rdata = 32'h0;
    checkOutput("ld_req_off", {31'b0, bus.dmem_req},       32'h0);
    checkOutput("ld_mdata",   mem_data_out,                32'hDEADBEEF);
    checkOutput("ld_rfw",     {31'b0, reg_file_write_out}, 32'h1);
    checkOutput("ld_alu",     alu_out,                     32'h100);
    checkOutput("ld_sel",     {30'b0, select_mux_4_out},   32'h2);

    // Store at 0x204, ack in first request cycle
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 32'h12345678, 32'h204, 32'h0);
    checkOutput("st_stall_n", {31'b0, stall_out}, 32'h1);
    tick();
    checkOutput("st_req",   {31'b0, bus.dmem_req}, 32'h1);
    checkOutput("st_we",    {31'b0, bus.dmem_we},  32'h1);
    checkOutput("st_wdata", bus.dmem_wdata,        32'h12345678);
    checkOutput("st_addr",  bus.dmem_addr,         32'h204);
    bus.dmem_ack   = 1'b1;
    bus.dmem_rdata = 32'hFFFFFFFF;
    #1;
    checkOutput("st_stall1", {31'b0, stall_out}, 32'h0);
    tick();
    bus.dmem_ack = 1'b0;
    checkOutput("st_req_off", {31'b0, bus.dmem_req},       32'h0);
    checkOutput("st_rfw",     {31'b0, reg_file_write_out}, 32'h0);
    checkOutput("st_mdata",   mem_data_out,                32'h0);

    // Misaligned load at 0x102
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 2'b10, 32'h0, 32'h102, 32'h0);
    checkOutput("mis_stall", {31'b0, stall_out}, 32'h0);
    tick();
    checkOutput("mis_req",  {31'b0, bus.dmem_req},       32'h0);
    checkOutput("mis_flag", {31'b0, misaligned_out},     32'h1);
    checkOutput("mis_rfw",  {31'b0, reg_file_write_out}, 32'h0);

    // Load that times out after 4 request cycles
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 2'b10, 32'h0, 32'h300, 32'h0);
    checkOutput("to_stall_n", {31'b0, stall_out}, 32'h1);
    tick();
    checkOutput("to_misclr", {31'b0, misaligned_out}, 32'h0);
    for (int i = 1; i <= 3; i++) begin
      checkOutput($sformatf("to_req%0d", i),   {31'b0, bus.dmem_req}, 32'h1);
      checkOutput($sformatf("to_stall%0d", i), {31'b0, stall_out},    32'h1);
      tick();
    end
    checkOutput("to_req4",   {31'b0, bus.dmem_req}, 32'h1);
    checkOutput("to_stall4", {31'b0, stall_out},    32'h0);
    tick();
    checkOutput("to_req_off", {31'b0, bus.dmem_req},       32'h0);
    checkOutput("to_err",     {31'b0, bus_err_out},        32'h1);
    checkOutput("to_rfw",     {31'b0, reg_file_write_out}, 32'h0);
    checkOutput("to_mdata",   mem_data_out,                32'h0);

    // Late ack while IDLE is ignored; ALU op proceeds normally
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 32'h0, 32'h20, 32'h0);
    bus.dmem_ack   = 1'b1;
    bus.dmem_rdata = 32'hCAFEF00D;
    #1;
    checkOutput("late_stall", {31'b0, stall_out}, 32'h0);
    tick();
    bus.dmem_ack = 1'b0;
    checkOutput("late_req",   {31'b0, bus.dmem_req},       32'h0);
    checkOutput("late_mdata", mem_data_out,                32'h0);
    checkOutput("late_rfw",   {31'b0, reg_file_write_out}, 32'h1);
    checkOutput("late_err",   {31'b0, bus_err_out},        32'h0);
    checkOutput("late_alu",   alu_out,                     32'h20);

    // Ack coincident with timeout: ack wins
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 2'b10, 32'h0, 32'h400, 32'h0);
    tick();
    tick();
    tick();
    tick();
    checkOutput("tie_req", {31'b0, bus.dmem_req}, 32'h1);
    bus.dmem_ack   = 1'b1;
    bus.dmem_rdata = 32'h0BADF00D;
    #1;
    tick();
    bus.dmem_ack = 1'b0;
    checkOutput("tie_mdata", mem_data_out,                32'h0BADF00D);
    checkOutput("tie_err",   {31'b0, bus_err_out},        32'h0);
    checkOutput("tie_rfw",   {31'b0, reg_file_write_out}, 32'h1);

    // Branch redirect is combinational
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 32'h0, 32'h0, 32'h80);
    checkOutput("br_src",    {31'b0, pc_src_out}, 32'h1);
    checkOutput("br_target", branch_target_out,   32'h80);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h84);
    checkOutput("br_src_off", {31'b0, pc_src_out}, 32'h0);
    tick();

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM stage of the 5-stage RV32 pipeline. It sits between the EX/MEM register (driven by the ex stage) and writeback.
- Performs word loads and stores over a req/ack data-memory port.
- Stalls upstream stages while an access is outstanding, times out dead accesses, and flags misaligned addresses.
- Resolves branch redirect to fetch and holds the MEM/WB pipeline register.

Parameters:
TIMEOUT_CYCLES, 16, max cycles dmem_req stays high without dmem_ack before the access is aborted (>=1)
CNT_W, 5, timeout counter width; must hold TIMEOUT_CYCLES

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-low reset
mem_re_in  in  1  load request from EX/MEM
mem_we_in  in  1  store request from EX/MEM
reg_file_write_in  in  1  register write enable from EX/MEM
branch_in  in  1  branch taken from EX/MEM
select_mux_4_in  in  2  writeback source select, passed through
reg_b_in  in  32  store data
alu_in  in  32  ALU result / memory address
add_pc_in  in  32  branch target
dmem_req  out  1  memory request, registered
dmem_we  out  1  1=write, registered
dmem_addr  out  32  word address, registered
dmem_wdata  out  32  store data, registered
dmem_rdata  in  32  load data, valid when dmem_ack=1
dmem_ack  in  1  access complete
stall_out  out  1  hold PC, IF/ID, ID/EX, EX/MEM (combinational)
pc_src_out  out  1  redirect fetch (combinational)
branch_target_out  out  32  redirect address (combinational)
reg_file_write_out  out  1  MEM/WB write enable
select_mux_4_out  out  2  MEM/WB writeback select
mem_data_out  out  32  MEM/WB load data
alu_out  out  32  MEM/WB ALU result
misaligned_out  out  1  MEM/WB: instruction had misaligned access
bus_err_out  out  1  MEM/WB: access timed out

Behaviour:
- Reset (reset=0 at a clock edge):
  - State goes to IDLE; counter cleared.
  - All registered outputs go to 0.
  - Combinational outputs stall_out and pc_src_out are forced 0 while reset=0; branch_target_out tracks add_pc_in.
  - Reset during WAIT abandons the access; dmem_req is 0 after that edge.
- Access definition:
  - access = mem_re_in | mem_we_in.
  - aligned = (alu_in[1:0]==0).
  - If both mem_re_in and mem_we_in are 1, the access is a store (we priority).
- FSM states: IDLE, WAIT.
- IDLE, no access:
  - stall_out=0.
  - MEM/WB loads reg_file_write_in, select_mux_4_in, alu_in; mem_data_out=0; flags=0.
  - Latency 1 cycle.
- IDLE, access and misaligned:
  - No request, stall_out=0.
  - MEM/WB loads with reg_file_write_out=0 and misaligned_out=1.
- IDLE, access and aligned:
  - stall_out=1.
  - At the edge: dmem_req<=1, dmem_we<=mem_we_in, dmem_addr<=alu_in, dmem_wdata<=reg_b_in; cnt<=1; go to WAIT.
- WAIT:
  - dmem_req/we/addr/wdata are held stable.
  - stall_out = ~(dmem_ack | cnt==TIMEOUT_CYCLES).
  - If dmem_ack=1:
    - dmem_req<=0; go to IDLE.
    - MEM/WB loads mem_data_out<=dmem_rdata (load) or 0 (store), plus reg_file_write_in, alu_in, select.
  - Else if cnt==TIMEOUT_CYCLES:
    - dmem_req<=0; go to IDLE.
    - MEM/WB loads bus_err_out=1, reg_file_write_out=0, mem_data_out=0.
  - Else cnt<=cnt+1.
  - If ack and timeout fall in the same cycle, ack wins.
- Any edge with stall_out=1:
  - MEM/WB inserts a bubble: reg_file_write_out=0, misaligned_out=0, bus_err_out=0; other fields hold.
- Latency:
  - Request visible at cycle N+1 for an instruction present at cycle N.
  - Ack at cycle N+k (k>=1) means stall_out is high for cycles N..N+k-1 and low in N+k.
  - Result lands in MEM/WB at the end of N+k.
- dmem_ack while in IDLE (late or spurious) is ignored.
- pc_src_out = branch_in; branch_target_out = add_pc_in. Neither is affected by stall, since branches carry no memory access.

Test Plan:
1. Assert reset=0 for 2 cycles with mem_re_in=1, then assert reset=0 mid-WAIT -> all outputs 0, dmem_req=0 next edge, state IDLE.
2. ALU op: reg_file_write_in=1, alu_in=0x00000010, select=2'b01 -> next edge alu_out=0x10, reg_file_write_out=1, stall_out never high.
3. Load at 0x00000100, ack on 3rd request cycle with rdata=0xDEADBEEF -> dmem_req high 3 cycles, stall_out high 3 cycles, then mem_data_out=0xDEADBEEF, reg_file_write_out=1.
4. Store at 0x00000204, reg_b_in=0x12345678, ack in 1st request cycle -> dmem_we=1, dmem_wdata=0x12345678, stall_out high 1 cycle, reg_file_write_out=0.
5. Load at 0x00000102 -> no dmem_req, misaligned_out=1, reg_file_write_out=0, no stall.
6. TIMEOUT_CYCLES=4, load with no ack, then ack arrives in IDLE; separately branch_in=1, add_pc_in=0x80 -> first case: req high 4 cycles, bus_err_out=1, write suppressed, late ack ignored; second case: pc_src_out=1, branch_target_out=0x80 in the same cycle.
